// File: rtl/fractal_pixel_source.sv
// Raster-scan pixel source for the fractal_kernel chain: one fixed-point complex coordinate per accepted cycle.
// Optional build macro JULIA_MODE_EN selects Julia-set operand mapping (extra jr/ji inputs).
module fractal_pixel_source #(
    parameter int DATA_WIDTH       = 32,
    parameter int FRACTIONAL_WIDTH = 28,
    parameter int H_RES            = 1920,
    parameter int V_RES            = 1080
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] x0,
    input  logic signed [DATA_WIDTH-1:0] y0,
    input  logic signed [DATA_WIDTH-1:0] dx,
    input  logic signed [DATA_WIDTH-1:0] dy,
`ifdef JULIA_MODE_EN
    input  logic signed [DATA_WIDTH-1:0] jr,
    input  logic signed [DATA_WIDTH-1:0] ji,
`endif
    input  logic                         ready,
    output logic signed [DATA_WIDTH-1:0] zr_out,
    output logic signed [DATA_WIDTH-1:0] zi_out,
    output logic signed [DATA_WIDTH-1:0] cr_out,
    output logic signed [DATA_WIDTH-1:0] ci_out,
    output logic [7:0]                   iter_out,
    output logic                         finished_out,
    output logic                         valid_out,
    output logic                         sof_out,
    output logic                         eol_out,
    output logic                         busy,
    output logic                         done
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

    // The fractional point position only matters to the kernel; a format with no integer bits is meaningless.
    if (FRACTIONAL_WIDTH >= DATA_WIDTH) begin : g_bad_fixed_point_format
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [DATA_WIDTH-1:0]   cur_r_q, cur_r_d;
    logic [DATA_WIDTH-1:0]   cur_i_q, cur_i_d;
    logic [DATA_WIDTH-1:0]   x0_q, x0_d;
    logic [DATA_WIDTH-1:0]   dx_q, dx_d;
    logic [DATA_WIDTH-1:0]   dy_q, dy_d;
`ifdef JULIA_MODE_EN
    logic [DATA_WIDTH-1:0]   jr_q, jr_d;
    logic [DATA_WIDTH-1:0]   ji_q, ji_d;
`endif
    logic [DATA_WIDTH-1:0]   zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic                    fin_q, fin_d, sof_q, sof_d, eol_q, eol_d;

    // Next-state, scan counters, coordinate accumulators and the registered kernel bus.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cur_r_d = cur_r_q;
        cur_i_d = cur_i_q;
        x0_d    = x0_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
`ifdef JULIA_MODE_EN
        jr_d    = jr_q;
        ji_d    = ji_q;
`endif
        zr_d    = ZERO_W;
        zi_d    = ZERO_W;
        cr_d    = ZERO_W;
        ci_d    = ZERO_W;
        fin_d   = 1'b1;
        sof_d   = 1'b0;
        eol_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    dx_d    = dx;
                    dy_d    = dy;
`ifdef JULIA_MODE_EN
                    jr_d    = jr;
                    ji_d    = ji;
`endif
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                    cur_r_d = x0;
                    cur_i_d = y0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ready) begin
                    fin_d = 1'b0;
                    sof_d = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
                    eol_d = (x_q == X_LAST);
`ifdef JULIA_MODE_EN
                    zr_d  = cur_r_q;
                    zi_d  = cur_i_q;
                    cr_d  = jr_q;
                    ci_d  = ji_q;
`else
                    cr_d  = cur_r_q;
                    ci_d  = cur_i_q;
`endif
                    // Line restart reloads x0 rather than accumulating, so dx error never drifts across lines.
                    if (x_q == X_LAST) begin
                        x_d     = {XW{1'b0}};
                        cur_r_d = x0_q;
                        if (y_q == Y_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            y_d     = y_q + YW'(1);
                            cur_i_d = cur_i_q + dy_q;
                        end
                    end else begin
                        x_d     = x_q + XW'(1);
                        cur_r_d = cur_r_q + dx_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched frame parameters and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            cur_r_q <= ZERO_W;
            cur_i_q <= ZERO_W;
            x0_q    <= ZERO_W;
            dx_q    <= ZERO_W;
            dy_q    <= ZERO_W;
`ifdef JULIA_MODE_EN
            jr_q    <= ZERO_W;
            ji_q    <= ZERO_W;
`endif
            zr_q    <= ZERO_W;
            zi_q    <= ZERO_W;
            cr_q    <= ZERO_W;
            ci_q    <= ZERO_W;
            fin_q   <= 1'b1;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cur_r_q <= cur_r_d;
            cur_i_q <= cur_i_d;
            x0_q    <= x0_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
`ifdef JULIA_MODE_EN
            jr_q    <= jr_d;
            ji_q    <= ji_d;
`endif
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            fin_q   <= fin_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign zr_out       = zr_q;
    assign zi_out       = zi_q;
    assign cr_out       = cr_q;
    assign ci_out       = ci_q;
    assign iter_out     = 8'h00;
    assign finished_out = fin_q;
    assign valid_out    = ~fin_q;
    assign sof_out      = sof_q;
    assign eol_out      = eol_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule
